multicycle_ctrl: RTL and testbench

//  FSM controller sequencing a multi-cycle MIPS datapath: shared instr/data memory, IR, PC, ALUOut, MDR.

---
 rtl/multicycle_ctrl_if.sv | 22 ++
 rtl/multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Memory port handshake between the multi-cycle controller and the shared instruction/data memory.
// The controller is the master: it requests, selects the address source and strobes writes.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// FSM controller for a multi-cycle MIPS datapath sharing one memory port for instructions and data.
// Sequences FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready and halts on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_ctrl_if.master        mem,
    input  logic [5:0]               opcode,
    input  logic [5:0]               funct,
    input  logic                     zero,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic [1:0]               pc_src,
    output logic                     reg_write,
    output logic [1:0]               reg_dst,
    output logic [1:0]               mem_to_reg,
    output logic                     alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               alu_op,
    output logic                     retire,
    output logic                     illegal,
    output logic                     timeout,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
    } class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(TIMEOUT);

    state_t                state_q, state_d;
    class_t                class_q, class_d, dec_class;
    logic [TIMEOUT_W-1:0]  wait_q, wait_d;
    logic                  illegal_q, illegal_d;
    logic                  timeout_q, timeout_d;
    logic                  mem_req_c, mem_we_c, iord_c;

    always_comb begin
        dec_class = C_ILL;
        case (opcode)
            OP_RTYPE: dec_class = (funct == FN_JR) ? C_JR : C_R;
            OP_J:     dec_class = C_J;
            OP_JAL:   dec_class = C_JAL;
            OP_BEQ:   dec_class = C_BEQ;
            OP_BNE:   dec_class = C_BNE;
            OP_ADDI:  dec_class = C_ADDI;
            OP_LW:    dec_class = C_LW;
            OP_SW:    dec_class = C_SW;
            default:  dec_class = C_ILL;
        endcase
    end

    // Async reset drops state to RST, so the memory strobes fall with rst_n without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            class_q   <= C_R;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        wait_d     = wait_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        iord_c     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;

            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                    state_d   = S_DECODE;
                end
            end

            S_DECODE: begin
                alu_src_b = 2'b11;
                class_d   = dec_class;
                case (dec_class)
                    C_J, C_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                        if (dec_class == C_JAL) begin
                            reg_write  = 1'b1;
                            reg_dst    = 2'b10;
                            mem_to_reg = 2'b10;
                        end
                    end
                    C_JR: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b11;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_ILL: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                alu_src_a = 1'b1;
                case (class_q)
                    C_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    C_ADDI: begin
                        alu_src_b = 2'b10;
                        state_d   = S_WB;
                    end
                    C_LW, C_SW: begin
                        alu_src_b = 2'b10;
                        state_d   = S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        alu_op   = 2'b01;
                        pc_src   = 2'b01;
                        pc_write = zero ^ (class_q == C_BNE);
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end

            S_MEM: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                mem_we_c  = (class_q == C_SW);
                if (mem.mem_ready) begin
                    if (class_q == C_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
                if (class_q == C_R) begin
                    reg_dst = 2'b01;
                end else if (class_q == C_LW) begin
                    mem_to_reg = 2'b01;
                end
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_RST;
        endcase

        // Count consecutive stalled memory cycles; the limit overrides whatever the state chose.
        if (state_q == S_FETCH || state_q == S_MEM) begin
            if (mem.mem_ready) begin
                wait_d = '0;
            end else begin
                wait_d = wait_q + 1'b1;
                if (TIMEOUT != 0 && wait_d == WAIT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
        end
    end

    assign mem.mem_req = mem_req_c;
    assign mem.mem_we  = mem_we_c;
    assign mem.iord    = iord_c;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: walks each instruction class cycle by cycle
// and checks state, selects and strobes against hand-computed values.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ir_write, pc_write, reg_write, alu_src_a, retire, illegal, timeout;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic [2:0] state;

    int checks;
    int failures;

    multicycle_ctrl_if memBus ();

    multicycle_ctrl #(
        .TIMEOUT   (4),
        .TIMEOUT_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (memBus.master),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .retire     (retire),
        .illegal    (illegal),
        .timeout    (timeout),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
        opcode           = op;
        funct            = fn;
        zero             = z;
        memBus.mem_ready = rdy;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(6'h00, 6'h00, 1'b0, 1'b0);
        #11;
        $display("[TB] reset state");
        checkOutput("rst_state", 32'(state), 0);
        checkOutput("rst_mem_req", 32'(memBus.mem_req), 0);
        checkOutput("rst_illegal", 32'(illegal), 0);
        stepClock();
        rst_n = 1'b1;

        $display("[TB] add");
        applyStimulus(6'h00, 6'h20, 1'b0, 1'b1);
        checkOutput("add_rst_state", 32'(state), 0);
        checkOutput("add_rst_pc_write", 32'(pc_write), 0);
        stepClock();
        checkOutput("add_fetch_state", 32'(state), 1);
        checkOutput("add_fetch_ctrl", 32'({memBus.mem_req, memBus.iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op}), 32'b1_0_1_1_00_0_01_00);
        stepClock();
        checkOutput("add_decode_state", 32'(state), 2);
        checkOutput("add_decode_b", 32'({alu_src_a, alu_src_b, alu_op, retire}), 32'b0_11_00_0);
        stepClock();
        checkOutput("add_exec_state", 32'(state), 3);
        checkOutput("add_exec_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1_00_10);
        stepClock();
        checkOutput("add_wb_state", 32'(state), 5);
        checkOutput("add_wb_ctrl", 32'({reg_write, reg_dst, mem_to_reg, retire}), 32'b1_01_00_1);
        stepClock();
        checkOutput("add_next_fetch", 32'(state), 1);

        $display("[TB] lw with memory stall");
        applyStimulus(6'h23, 6'h00, 1'b0, 1'b1);
        stepClock();
        checkOutput("lw_decode_state", 32'(state), 2);
        stepClock();
        checkOutput("lw_exec_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1_10_00);
        applyStimulus(6'h23, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            stepClock();
            if (i == 3) applyStimulus(6'h23, 6'h00, 1'b0, 1'b1);
            checkOutput($sformatf("lw_mem%0d_state", i), 32'(state), 4);
            checkOutput($sformatf("lw_mem%0d_ctrl", i), 32'({memBus.mem_req, memBus.iord, memBus.mem_we, retire}), 32'b1_1_0_0);
        end
        stepClock();
        checkOutput("lw_wb_state", 32'(state), 5);
        checkOutput("lw_wb_ctrl", 32'({reg_write, reg_dst, mem_to_reg, retire}), 32'b1_00_01_1);
        stepClock();

        $display("[TB] beq/bne");
        applyStimulus(6'h04, 6'h00, 1'b1, 1'b1);
        stepClock();
        stepClock();
        checkOutput("beq_exec_state", 32'(state), 3);
        checkOutput("beq_taken", 32'({pc_write, pc_src, alu_op, retire}), 32'b1_01_01_1);
        stepClock();
        checkOutput("beq_next_fetch", 32'(state), 1);
        applyStimulus(6'h05, 6'h00, 1'b1, 1'b1);
        stepClock();
        stepClock();
        checkOutput("bne_zero1", 32'({pc_write, pc_src, retire}), 32'b0_01_1);
        applyStimulus(6'h05, 6'h00, 1'b0, 1'b1);
        checkOutput("bne_zero0", 32'(pc_write), 1);
        stepClock();
        checkOutput("bne_next_fetch", 32'(state), 1);

        $display("[TB] jal/jr");
        applyStimulus(6'h03, 6'h00, 1'b0, 1'b1);
        stepClock();
        checkOutput("jal_decode", 32'({pc_write, pc_src, reg_write, reg_dst, mem_to_reg, retire}), 32'b1_10_1_10_10_1);
        stepClock();
        checkOutput("jal_next_fetch", 32'(state), 1);
        applyStimulus(6'h00, 6'h08, 1'b0, 1'b1);
        stepClock();
        checkOutput("jr_decode", 32'({pc_write, pc_src, reg_write, retire}), 32'b1_11_0_1);
        stepClock();
        checkOutput("jr_next_fetch", 32'(state), 1);

        $display("[TB] illegal opcode");
        applyStimulus(6'h3F, 6'h00, 1'b0, 1'b1);
        stepClock();
        stepClock();
        checkOutput("ill_halt_state", 32'(state), 7);
        checkOutput("ill_flag", 32'(illegal), 1);
        for (int i = 0; i < 20; i++) begin
            stepClock();
            checkOutput($sformatf("ill_halt%0d_mem_req", i), 32'({state, memBus.mem_req}), 32'b111_0);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("ill_rst_flag", 32'(illegal), 0);
        checkOutput("ill_rst_state", 32'(state), 0);
        stepClock();
        rst_n = 1'b1;

        $display("[TB] fetch timeout");
        applyStimulus(6'h00, 6'h20, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            stepClock();
            checkOutput($sformatf("to_wait%0d", i), 32'({state, timeout}), 32'b001_0);
        end
        stepClock();
        checkOutput("to_halt", 32'({state, timeout}), 32'b111_1);
        rst_n = 1'b0;
        #1;
        checkOutput("to_rst_flag", 32'(timeout), 0);
        stepClock();
        rst_n = 1'b1;

        $display("[TB] sw then reset mid-access");
        applyStimulus(6'h2B, 6'h00, 1'b0, 1'b1);
        stepClock();
        stepClock();
        stepClock();
        stepClock();
        checkOutput("sw_mem_ctrl", 32'({state, memBus.mem_req, memBus.iord, memBus.mem_we, retire}), 32'b100_1_1_1_1);
        stepClock();
        checkOutput("sw_next_fetch", 32'(state), 1);
        stepClock();
        stepClock();
        applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0);
        stepClock();
        checkOutput("sw_stall_we", 32'({state, memBus.mem_we}), 32'b100_1);
        rst_n = 1'b0;
        #1;
        checkOutput("sw_rst_strobes", 32'({state, memBus.mem_req, memBus.mem_we}), 32'b000_0_0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
